disp_scan_sched: RTL
====================

// Module: disp_scan_sched
// PURPOSE
//  Time-multiplexed display scheduler for the traffic light controller. Shares one
//  combinational BIN2BCD converter (6-bit in, {tens,ones} BCD out) among N_LANES
//  countdown values and scans 2*N_LANES common-anode 7-seg digits, one per SCAN_DIV
//  clocks. Sits between the lane timer block and the board display pins.
// PARAMETERS
//  N_LANES   4      number of lanes; 2 digits each (tens, ones)
//  SCAN_DIV  50000  clk cycles per digit slot; legal range 4..2^20
// PORTS
//  clk         in   1          system clock
//  rst         in   1          synchronous, active-high reset
//  lane_time   in   6*N_LANES  lane i countdown value in bits [6i+5:6i], 0..63 s
//  lane_valid  in   N_LANES    1 = lane i value shown; 0 = both digits blank
//  conv_bin    out  6          operand driven to the shared BIN2BCD
//  conv_bcd    in   8          BIN2BCD result {tens[7:4],ones[3:0]}, combinational from conv_bin
//  digit_en    out  2*N_LANES  one-hot digit select, active-high; bit 2i = lane i ones, 2i+1 = tens
//  digit_bcd   out  4          BCD nibble of active digit; 4'hF when blanked
//  seg         out  7          segments {g..a}, active-high
//  frame_start out  1          1-cycle pulse when lane snapshot is taken
// BEHAVIOUR
//  - Clock is clk; reset is synchronous, active-high, on rst.
//  - Reset: prescaler=0, idx=0, state=IDLE, conv_bin=0, digit_en=0, digit_bcd=4'hF,
//    seg=0, frame_start=0, shadow regs=0. Reset mid-slot aborts the slot and blanks
//    the display on the next edge.
//  - Prescaler counts 0..SCAN_DIV-1 and wraps; tick asserts at SCAN_DIV-1.
//    Counting starts the cycle after rst deasserts.
//  - FSM: IDLE -tick-> LOAD -> CAPTURE -> SHOW -tick-> LOAD ...
//    LOAD    (1 cycle): digit_en=0; conv_bin <= shadow_time[idx>>1]. If idx==0, first
//            copy lane_time/lane_valid into shadow regs, drive conv_bin from the new
//            value, and pulse frame_start.
//    CAPTURE (1 cycle): digit_en=0; digit_bcd <= idx[0] ? conv_bcd[7:4] : conv_bcd[3:0].
//    SHOW: digit_en = 1<<idx; seg = decode(digit_bcd). On tick: idx <= idx+1,
//          wrapping 2*N_LANES-1 -> 0; go to LOAD.
//  - Each slot lasts SCAN_DIV cycles, including 2 blank cycles (anti-ghosting).
//    Frame period = 2*N_LANES*SCAN_DIV.
//  - Snapshot only at idx==0 LOAD: lane_time changes mid-frame never tear a lane's digit pair.
//  - lane_valid=0 in the snapshot: digit_bcd=4'hF and seg=0 for both digits; digit_en
//    still walks.
//  - Values 60..63 show tens digit 6; no saturation or clamping.
//  - Nibbles 10..15 decode to seg=0.
//  - lane_time and lane_valid are sampled only at snapshot; no handshake.
// CONFIGURATION
//  DISP_LZB_EN defined: leading-zero blanking. When the tens digit is 0, that digit
//    shows digit_bcd=4'hF and seg=0. Value 0 shows a single "0".
//  DISP_LZB_EN undefined: tens digit 0 is shown as "0" (e.g. 5 -> "05").
// STRUCTURE
//  - Package traffic_disp_pkg:
//    - LANE_W=6, BCD_BLANK=4'hF
//    - FSM state typedef {IDLE,LOAD,CAPTURE,SHOW}
//    - SEG_0..SEG_9 segment constants
//  - Sub-module seg7_decode: combinational BCD -> seg, uses package constants.
//  - BIN2BCD is instantiated by the parent and connected through conv_bin/conv_bcd;
//    it is not inside this block.
// TESTING (SCAN_DIV=4, N_LANES=4, BIN2BCD model attached)
//  1 Reset, lane_time={63,0,9,42}, valid=4'hF -> after reset all outputs are 0/4'hF.
//    frame_start is at cycle 4; digit_en then steps 01,02,04..80.
//    Digit order (ones,tens per lane 0..3): 2,4,9,0,0,0,3,6.
//  2 Blanking: every slot -> exactly 2 cycles with digit_en=0, then 2 cycles one-hot.
//    No two digit_en bits are ever set.
//  3 Change lane0 42->17 during slot idx=3 -> the rest of that frame still shows 4/2;
//    the next frame shows 7/1.
//  4 lane_valid=4'b1011 -> lane2 slots show digit_bcd=F, seg=0; the others are unaffected.
//  5 Assert rst for 1 cycle during SHOW of idx=5 -> next edge digit_en=0, idx=0, state=IDLE.
//    The scan restarts with frame_start.
//  6 DISP_LZB_EN on, lane value 9 -> tens slot blank, ones shows 9; value 0 -> tens blank,
//    ones "0". With the macro off, value 9 -> tens shows 0.

Source files
------------

// File: rtl/disp_scan_sched_pkg.sv
// Shared types and constants for the traffic-light display scan scheduler.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package traffic_disp_pkg;

    localparam int          LANE_W    = 6;
    localparam logic [3:0]  BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CAPTURE = 2'd2,
        SHOW    = 2'd3
    } disp_state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;

endpackage

// File: rtl/disp_scan_sched_if.sv
// Bundle between the scan scheduler, the lane timer block, the shared BIN2BCD and the pins.
// master = scheduler side, slave = surrounding system.
interface disp_scan_sched_if #(
    parameter int N_LANES = 4
);
    logic [traffic_disp_pkg::LANE_W*N_LANES-1:0] lane_time;
    logic [N_LANES-1:0]                          lane_valid;
    logic [traffic_disp_pkg::LANE_W-1:0]         conv_bin;
    logic [7:0]                                  conv_bcd;
    logic [2*N_LANES-1:0]                        digit_en;
    logic [3:0]                                  digit_bcd;
    logic [6:0]                                  seg;
    logic                                        frame_start;

    modport master (
        input  lane_time, lane_valid, conv_bcd,
        output conv_bin, digit_en, digit_bcd, seg, frame_start
    );

    modport slave (
        output lane_time, lane_valid, conv_bcd,
        input  conv_bin, digit_en, digit_bcd, seg, frame_start
    );
endinterface

// File: rtl/disp_scan_sched_seg7_decode.sv
// Combinational BCD nibble to 7-segment decoder; nibbles 10..15 (incl. blank) give all-off.
module seg7_decode
    import traffic_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_sched.sv
// Time-multiplexed 7-seg scan scheduler sharing one external BIN2BCD across all lanes.
// Optional leading-zero blanking of the tens digit when DISP_LZB_EN is defined.
module disp_scan_sched
    import traffic_disp_pkg::*;
#(
    parameter int N_LANES  = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    disp_scan_sched_if.master bus
);

    localparam int DW = 2 * N_LANES;
    localparam int IW = $clog2(DW);
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TW = LANE_W * N_LANES;

    disp_state_e       state_reg, state_next;
    logic [PW-1:0]     presc_reg, presc_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [TW-1:0]     shadow_time_reg, shadow_time_next;
    logic [N_LANES-1:0] shadow_valid_reg, shadow_valid_next;
    logic [LANE_W-1:0] conv_bin_reg, conv_bin_next;
    logic [DW-1:0]     digit_en_reg, digit_en_next;
    logic [3:0]        digit_bcd_reg, digit_bcd_next;
    logic              frame_start_reg, frame_start_next;

    logic              tick;
    logic              idx_last;
    logic [LW-1:0]     lane;
    logic [3:0]        capt_nib;
    logic [6:0]        seg_dec;
    logic [LANE_W-1:0] shadow_lane [N_LANES];

    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_shadow_lane
        assign shadow_lane[gi] = shadow_time_reg[gi*LANE_W +: LANE_W];
    end

    assign tick     = (presc_reg == PW'(SCAN_DIV - 1));
    assign idx_last = (idx_reg == IW'(DW - 1));
    assign lane     = LW'(idx_reg >> 1);

    always_comb begin
        state_next        = state_reg;
        presc_next        = tick ? '0 : presc_reg + PW'(1);
        idx_next          = idx_reg;
        shadow_time_next  = shadow_time_reg;
        shadow_valid_next = shadow_valid_reg;
        conv_bin_next     = conv_bin_reg;
        digit_en_next     = digit_en_reg;
        digit_bcd_next    = digit_bcd_reg;
        frame_start_next  = 1'b0;
        capt_nib          = idx_reg[0] ? bus.conv_bcd[7:4] : bus.conv_bcd[3:0];

        if (!shadow_valid_reg[lane]) begin
            capt_nib = BCD_BLANK;
        end
`ifdef DISP_LZB_EN
        if (idx_reg[0] && (bus.conv_bcd[7:4] == 4'd0)) begin
            capt_nib = BCD_BLANK;
        end
`endif

        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next       = LOAD;
                    frame_start_next = (idx_reg == '0);
                end
            end
            LOAD: begin
                state_next = CAPTURE;
                // Snapshot the whole frame at once so a lane's digit pair never tears.
                if (idx_reg == '0) begin
                    shadow_time_next  = bus.lane_time;
                    shadow_valid_next = bus.lane_valid;
                    conv_bin_next     = bus.lane_time[LANE_W-1:0];
                end else begin
                    conv_bin_next     = shadow_lane[lane];
                end
            end
            CAPTURE: begin
                state_next     = SHOW;
                digit_bcd_next = capt_nib;
                digit_en_next  = DW'(1) << idx_reg;
            end
            SHOW: begin
                if (tick) begin
                    state_next       = LOAD;
                    digit_en_next    = '0;
                    idx_next         = idx_last ? '0 : idx_reg + IW'(1);
                    frame_start_next = idx_last;
                end
            end
            default: begin
                state_next    = IDLE;
                digit_en_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            presc_reg        <= '0;
            idx_reg          <= '0;
            shadow_time_reg  <= '0;
            shadow_valid_reg <= '0;
            conv_bin_reg     <= '0;
            digit_en_reg     <= '0;
            digit_bcd_reg    <= BCD_BLANK;
            frame_start_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            presc_reg        <= presc_next;
            idx_reg          <= idx_next;
            shadow_time_reg  <= shadow_time_next;
            shadow_valid_reg <= shadow_valid_next;
            conv_bin_reg     <= conv_bin_next;
            digit_en_reg     <= digit_en_next;
            digit_bcd_reg    <= digit_bcd_next;
            frame_start_reg  <= frame_start_next;
        end
    end

    seg7_decode u_seg7_decode (
        .bcd (digit_bcd_reg),
        .seg (seg_dec)
    );

    assign bus.conv_bin    = conv_bin_reg;
    assign bus.digit_en    = digit_en_reg;
    assign bus.digit_bcd   = digit_bcd_reg;
    assign bus.seg         = seg_dec;
    assign bus.frame_start = frame_start_reg;

endmodule
